// File: rtl/serdes_tx_serializer.sv
// serdes_tx_serializer: parallel-to-serial transmitter with a small input FIFO.
// Words are accepted over valid/ready and shifted out LSB first, one bit per
// enabled clock, back-to-back with no gap bits. The line rests at IDLE_BIT.
module serdes_tx_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        IDLE_BIT   = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            ser_out,
    output logic                            ser_frame,
    output logic                            ser_active,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full, empty;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    // Shifter state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ser_out_q, ser_out_d;
    logic              frame_q, frame_d;
    logic              active_q, active_d;

    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    assign ser_out    = ser_out_q;
    assign ser_frame  = frame_q;
    assign ser_active = active_q;
    assign fifo_level = level_q;

    // Shifter next state: load from FIFO head, shift, or return to idle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ser_out_d = ser_out_q;
        frame_d   = frame_q;
        active_d  = active_q;
        pop       = 1'b0;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_d   = ST_SHIFT;
                        shreg_d   = head;
                        ser_out_d = head[0];
                        frame_d   = 1'b1;
                        active_d  = 1'b1;
                        cnt_d     = '0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        shreg_d   = shreg_q >> 1;
                        ser_out_d = shreg_q[1];
                        cnt_d     = cnt_q + CNT_W'(1);
                        frame_d   = 1'b0;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        shreg_d   = head;
                        ser_out_d = head[0];
                        frame_d   = 1'b1;
                        active_d  = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        ser_out_d = IDLE_BIT;
                        frame_d   = 1'b0;
                        active_d  = 1'b0;
                        cnt_d     = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            ser_out_q <= IDLE_BIT;
            frame_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ser_out_q <= ser_out_d;
            frame_q   <= frame_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: tb/tb_serdes_tx_serializer.sv
// Directed bench for serdes_tx_serializer (DATA_W=8, FIFO_DEPTH=4, IDLE_BIT=1).
module tb_serdes_tx_serializer;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_out;
    logic       ser_frame;
    logic       ser_active;
    logic [2:0] fifo_level;

    int n_cmp;
    int n_err;

    serdes_tx_serializer #(
        .DATA_W    (8),
        .FIFO_DEPTH(4),
        .IDLE_BIT  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_frame (ser_frame),
        .ser_active(ser_active),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick(); tick();
        n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL reset_ser_out: got %b expected 1", ser_out); end
        n_cmp++; if (ser_frame !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b expected 0", ser_frame); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b expected 0", ser_active); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready); end
    endtask

    // Single word: data bits for 8 cycles after edge E+1, then return to idle 1.
    task automatic send_single(input logic [7:0] word, input string tag);
        in_data = word; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL %s_level_queued: got %0d expected 1", tag, fifo_level); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL %s_not_yet_active: got %b expected 0", tag, ser_active); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (ser_out !== word[i]) begin n_err++; $display("FAIL %s_bit%0d: got %b expected %b", tag, i, ser_out, word[i]); end
            n_cmp++; if (ser_active !== 1'b1) begin n_err++; $display("FAIL %s_active%0d: got %b expected 1", tag, i, ser_active); end
            n_cmp++; if (ser_frame !== (i == 0)) begin n_err++; $display("FAIL %s_frame%0d: got %b expected %b", tag, i, ser_frame, (i == 0)); end
        end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL %s_level_drained: got %0d expected 0", tag, fifo_level); end
        tick();
        n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL %s_idle_out: got %b expected 1", tag, ser_out); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL %s_idle_active: got %b expected 0", tag, ser_active); end
        n_cmp++; if (ser_frame !== 1'b0) begin n_err++; $display("FAIL %s_idle_frame: got %b expected 0", tag, ser_frame); end
    endtask

    task automatic test_zero();
        send_single(8'h00, "zero");
    endtask

    task automatic test_a5();
        send_single(8'hA5, "a5");
    endtask

    task automatic test_back_to_back();
        logic [23:0] stream;
        logic [2:0]  exp_lvl;
        logic [2:0]  peak;
        stream = 24'h81FF3C;
        peak = 3'd0;
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL b2b_level_first: got %0d expected 1", fifo_level); end
        for (int k = 0; k <= 24; k++) begin
            if (k == 0)      begin in_data = 8'hFF; in_valid = 1'b1; end
            else if (k == 1) begin in_data = 8'h81; in_valid = 1'b1; end
            else             in_valid = 1'b0;
            tick();
            if (fifo_level > peak) peak = fifo_level;
            if (k == 0)       exp_lvl = 3'd1;
            else if (k < 8)   exp_lvl = 3'd2;
            else if (k < 16)  exp_lvl = 3'd1;
            else              exp_lvl = 3'd0;
            n_cmp++; if (fifo_level !== exp_lvl) begin n_err++; $display("FAIL b2b_level%0d: got %0d expected %0d", k, fifo_level, exp_lvl); end
            if (k < 24) begin
                n_cmp++; if (ser_out !== stream[k]) begin n_err++; $display("FAIL b2b_bit%0d: got %b expected %b", k, ser_out, stream[k]); end
                n_cmp++; if (ser_active !== 1'b1) begin n_err++; $display("FAIL b2b_active%0d: got %b expected 1", k, ser_active); end
                n_cmp++; if (ser_frame !== (k % 8 == 0)) begin n_err++; $display("FAIL b2b_frame%0d: got %b expected %b", k, ser_frame, (k % 8 == 0)); end
            end else begin
                n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL b2b_end_active: got %b expected 0", ser_active); end
                n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL b2b_end_out: got %b expected 1", ser_out); end
            end
        end
        n_cmp++; if (peak !== 3'd2) begin n_err++; $display("FAIL b2b_peak: got %0d expected 2", peak); end
    endtask

    task automatic test_full();
        logic [7:0] words [5];
        logic [7:0] w;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = words[i]; in_valid = 1'b1;
            n_cmp++; if (in_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready_before%0d: got %b expected %b", i, in_ready, (i < 4)); end
            tick();
        end
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: got %b expected 0", in_ready); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL full_paused_idle: got %b expected 0", ser_active); end
        ena = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            in_valid = (k < 2);
            tick();
            if (k == 0) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got %b expected 1", in_ready); end
                n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL full_level_after_pop: got %0d expected 3", fifo_level); end
            end
            if (k == 1) begin
                n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level_refill: got %0d expected 4", fifo_level); end
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_refill: got %b expected 0", in_ready); end
            end
            if (k < 40) begin
                w = words[k / 8];
                n_cmp++; if (ser_out !== w[k % 8]) begin n_err++; $display("FAIL full_bit%0d: got %b expected %b", k, ser_out, w[k % 8]); end
                n_cmp++; if (ser_frame !== (k % 8 == 0)) begin n_err++; $display("FAIL full_frame%0d: got %b expected %b", k, ser_frame, (k % 8 == 0)); end
            end else begin
                n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL full_end_active: got %b expected 0", ser_active); end
                n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL full_end_level: got %0d expected 0", fifo_level); end
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] word;
        int         bi;
        word = 8'hC3;
        in_data = word; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s <= 11; s++) begin
            ena = !(s >= 4 && s <= 6);
            tick();
            if (s <= 3)      bi = s;
            else if (s <= 6) bi = 3;
            else             bi = s - 3;
            if (s <= 10) begin
                n_cmp++; if (ser_out !== word[bi]) begin n_err++; $display("FAIL pause_s%0d: got %b expected %b", s, ser_out, word[bi]); end
                n_cmp++; if (ser_active !== 1'b1) begin n_err++; $display("FAIL pause_active%0d: got %b expected 1", s, ser_active); end
                n_cmp++; if (ser_frame !== (s == 0)) begin n_err++; $display("FAIL pause_frame%0d: got %b expected %b", s, ser_frame, (s == 0)); end
            end else begin
                n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL pause_end_active: got %b expected 0", ser_active); end
                n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL pause_end_out: got %b expected 1", ser_out); end
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] w0;
        int         act_cycles;
        w0 = 8'h5A;
        in_data = w0; in_valid = 1'b1;
        tick();
        in_data = 8'h96;
        tick();
        in_data = 8'hE7;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL rstmid_level_queued: got %0d expected 2", fifo_level); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (ser_out !== w0[5]) begin n_err++; $display("FAIL rstmid_bit5: got %b expected %b", ser_out, w0[5]); end
        rst = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL rstmid_out: got %b expected 1", ser_out); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rstmid_level: got %0d expected 0", fifo_level); end
        n_cmp++; if (ser_active !== 1'b0) begin n_err++; $display("FAIL rstmid_active: got %b expected 0", ser_active); end
        act_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ser_active !== 1'b0 || ser_out !== 1'b1) act_cycles++;
        end
        n_cmp++; if (act_cycles !== 0) begin n_err++; $display("FAIL rstmid_no_resume: got %0d non-idle cycles expected 0", act_cycles); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_zero();
        test_a5();
        test_back_to_back();
        test_full();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
